// File: rtl/regf_wb_queue.sv
// Write-back sequencer for register-file port C: merges ALU and memory results
// through an in-order FIFO and issues at most one write per cycle.
module regf_wb_queue #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     halt,
  input  logic                     flush_pipeline,
  input  logic                     alu_we,
  input  logic [AWIDTH-1:0]        alu_addr,
  input  logic [DWIDTH-1:0]        alu_data,
  input  logic                     mem_we,
  input  logic [AWIDTH-1:0]        mem_addr,
  input  logic [DWIDTH-1:0]        mem_data,
  output logic                     mem_ready,
  output logic                     wec,
  output logic [AWIDTH-1:0]        addrc,
  output logic [DWIDTH-1:0]        datac,
  output logic [$clog2(DEPTH):0]   wb_count,
  output logic                     wb_idle
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AWIDTH-1:0] r_addr_q [DEPTH];
  logic [DWIDTH-1:0] r_data_q [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_wec;
  logic [AWIDTH-1:0] r_addrc;
  logic [DWIDTH-1:0] r_datac;

  logic              w_fifo_ne;
  logic              w_alu_v;
  logic              w_mem_v;
  logic              w_pop;
  logic              w_sel_v;
  logic [AWIDTH-1:0] w_sel_addr;
  logic [DWIDTH-1:0] w_sel_data;
  logic              w_alu_push;
  logic              w_mem_push;
  logic              w_push0_v;
  logic              w_push1_v;
  logic [AWIDTH-1:0] w_push0_addr;
  logic [DWIDTH-1:0] w_push0_data;
  logic [PW-1:0]     w_wr_ptr1;
  logic [CW-1:0]     w_count_nxt;

  assign w_fifo_ne = (r_count != '0);
  assign mem_ready = (r_count <= CW'(DEPTH - 2));
  assign w_alu_v   = alu_we & ~halt;
  assign w_mem_v   = mem_we & mem_ready & ~halt;
  assign w_wr_ptr1 = r_wr_ptr + PW'(1);

  // Oldest first: FIFO head, then ALU, then memory; the rest is queued ALU-first.
  always_comb begin
    w_pop      = 1'b0;
    w_sel_v    = 1'b0;
    w_sel_addr = r_addr_q[r_rd_ptr];
    w_sel_data = r_data_q[r_rd_ptr];
    w_alu_push = 1'b0;
    w_mem_push = 1'b0;
    if (w_fifo_ne && !halt) begin
      w_pop      = 1'b1;
      w_sel_v    = 1'b1;
      w_alu_push = w_alu_v;
      w_mem_push = w_mem_v;
    end else if (w_alu_v) begin
      w_sel_v    = 1'b1;
      w_sel_addr = alu_addr;
      w_sel_data = alu_data;
      w_mem_push = w_mem_v;
    end else if (w_mem_v) begin
      w_sel_v    = 1'b1;
      w_sel_addr = mem_addr;
      w_sel_data = mem_data;
    end
  end

  assign w_push0_v    = w_alu_push | w_mem_push;
  assign w_push1_v    = w_alu_push & w_mem_push;
  assign w_push0_addr = w_alu_push ? alu_addr : mem_addr;
  assign w_push0_data = w_alu_push ? alu_data : mem_data;
  assign w_count_nxt  = r_count + CW'(w_push0_v) + CW'(w_push1_v) - CW'(w_pop);

  // FIFO storage, pointers and count; flush outranks halt.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr_q[i] <= '0;
        r_data_q[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_pipeline) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (!halt) begin
      if (w_push0_v) begin
        r_addr_q[r_wr_ptr] <= w_push0_addr;
        r_data_q[r_wr_ptr] <= w_push0_data;
      end
      if (w_push1_v) begin
        r_addr_q[w_wr_ptr1] <= mem_addr;
        r_data_q[w_wr_ptr1] <= mem_data;
      end
      r_wr_ptr <= r_wr_ptr + PW'(w_push0_v) + PW'(w_push1_v);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= w_count_nxt;
    end
  end

  // Port-C output register; address/data hold when nothing is issued.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wec   <= 1'b0;
      r_addrc <= '0;
      r_datac <= '0;
    end else if (flush_pipeline) begin
      r_wec   <= 1'b0;
    end else if (!halt) begin
      r_wec <= w_sel_v;
      if (w_sel_v) begin
        r_addrc <= w_sel_addr;
        r_datac <= w_sel_data;
      end
    end
  end

  // Pending write is masked while halted and re-presented once halt drops.
  assign wec      = r_wec & ~halt;
  assign addrc    = r_addrc;
  assign datac    = r_datac;
  assign wb_count = r_count;
  assign wb_idle  = ~w_fifo_ne & ~r_wec;

endmodule
